// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared constants, state encoding and helpers for the seq_div32
// multi-cycle restoring divider.
//   DIV_WIDTH  : operand/result width (fixed at 32, the add/sub unit is fixed-width)
//   DIV_CNT_W  : iteration counter width (must hold DIV_WIDTH)
//   ITER_COUNT : number of quotient bits produced, one per CALC cycle
//   DIV0_QUOT  : quotient returned on divide-by-zero
package seq_div_pkg;

    localparam int          DIV_WIDTH  = 32;
    localparam int          DIV_CNT_W  = 6;
    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    // Two's-complement negation; 32'h8000_0000 maps onto itself.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/seq_div32_add_sub.sv
// add_sub_unit: the single shared 32-bit adder/subtractor driven by seq_div32.
//   a, b : operands
//   sub  : 1 = a - b (a + ~b + 1), 0 = a + b
//   s    : 32-bit result
//   co   : carry out; for a subtract, 1 means no borrow (a >= b unsigned)
module add_sub_unit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] b_eff_s;
    logic [32:0] sum_s;

    // Invert the second operand and inject the carry-in for a subtract.
    always_comb begin
        b_eff_s = sub ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, sub};
    end

    assign s  = sum_s[31:0];
    assign co = sum_s[32];

endmodule

// File: rtl/seq_div32.sv
// seq_div32: multi-cycle restoring divider controller serving DIV/DIVU.
// Produces one quotient bit per clock using one shared add/sub unit.
// Optional signed support is compiled in with `define SEQDIV_SIGNED_EN.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start               : request pulse, sampled only in IDLE
//   sgn                 : signed division (honoured only with SEQDIV_SIGNED_EN)
//   dividend, divisor   : operands, captured on an accepted start
//   busy                : high in CALC/FIX
//   done                : one-cycle pulse when results are valid
//   div0                : divisor was zero; held until the next accepted start
//   quotient, remainder : results, held until the next completion
module seq_div32
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   r_r, q_r, d_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r, done_r, div0_r;
    logic [WIDTH-1:0]   quotient_r, remainder_r;

    logic [WIDTH-1:0]   a_s, b_s, s_s, p_s, r_new_s, q_new_s;
    logic               sub_s, co_s, take_s, last_iter_s;

`ifdef SEQDIV_SIGNED_EN
    logic               sgn_mode_r, neg_q_r, neg_rem_r;
`else
    logic               sgn_unused_s;
    assign sgn_unused_s = sgn;
`endif

    // Restoring step: R[31] set means the shifted partial remainder exceeds 2^32 > D.
    assign p_s         = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
    assign take_s      = r_r[WIDTH-1] | co_s;
    assign r_new_s     = take_s ? s_s : p_s;
    assign q_new_s     = {q_r[WIDTH-2:0], take_s};
    assign last_iter_s = (cnt_r == CNT_W'(1));

    add_sub_unit u_add_sub (
        .a   (a_s),
        .b   (b_s),
        .sub (sub_s),
        .s   (s_s),
        .co  (co_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
`ifdef SEQDIV_SIGNED_EN
                    state_nxt_s = sgn_mode_r ? FIX : DONE;
`else
                    state_nxt_s = DONE;
`endif
                end else begin
                    state_nxt_s = CALC;
                end
            end
`ifdef SEQDIV_SIGNED_EN
            FIX:     state_nxt_s = DONE;
`endif
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Add/sub operand steering: iteration subtract in CALC, negations otherwise.
    always_comb begin
        a_s   = p_s;
        b_s   = d_r;
        sub_s = 1'b1;
        case (state_r)
`ifdef SEQDIV_SIGNED_EN
            // Dividend magnitude on accept: 0 - dividend.
            IDLE: begin
                a_s   = '0;
                b_s   = dividend;
                sub_s = 1'b1;
            end
            // A negative divisor is kept raw and added: P + D == P - |D| with the
            // same carry meaning, so no separate divisor negation is needed.
            CALC: begin
                a_s   = p_s;
                b_s   = d_r;
                sub_s = ~(sgn_mode_r & d_r[WIDTH-1]);
            end
            FIX: begin
                a_s   = '0;
                b_s   = q_r;
                sub_s = 1'b1;
            end
`else
            CALC: begin
                a_s   = p_s;
                b_s   = d_r;
                sub_s = 1'b1;
            end
`endif
            default: begin
                a_s   = p_s;
                b_s   = d_r;
                sub_s = 1'b1;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            r_r         <= '0;
            q_r         <= '0;
            d_r         <= '0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            div0_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
`ifdef SEQDIV_SIGNED_EN
            sgn_mode_r  <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CALC) || (state_nxt_s == FIX);
            done_r  <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_r  <= DIV0_QUOT;
                            remainder_r <= dividend;
                            div0_r      <= 1'b1;
                        end else begin
                            div0_r <= 1'b0;
                            r_r    <= '0;
                            d_r    <= divisor;
                            cnt_r  <= CNT_W'(ITER_COUNT);
`ifdef SEQDIV_SIGNED_EN
                            sgn_mode_r <= sgn;
                            neg_q_r    <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_rem_r  <= sgn & dividend[WIDTH-1];
                            q_r        <= (sgn & dividend[WIDTH-1]) ? s_s : dividend;
`else
                            q_r        <= dividend;
`endif
                        end
                    end
                end
                CALC: begin
                    r_r   <= r_new_s;
                    q_r   <= q_new_s;
                    cnt_r <= cnt_r - CNT_W'(1);
`ifdef SEQDIV_SIGNED_EN
                    if (last_iter_s && !sgn_mode_r) begin
`else
                    if (last_iter_s) begin
`endif
                        quotient_r  <= q_new_s;
                        remainder_r <= r_new_s;
                    end
                end
`ifdef SEQDIV_SIGNED_EN
                // Truncating signed fix-up: quotient through the shared unit.
                FIX: begin
                    quotient_r  <= neg_q_r   ? s_s          : q_r;
                    remainder_r <= neg_rem_r ? neg32(r_r)   : r_r;
                end
`endif
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign div0      = div0_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_seq_div32.sv
// tb_seq_div32: directed self-checking bench for seq_div32 (unsigned build;
// signed vectors are added when SEQDIV_SIGNED_EN is defined).
module tb_seq_div32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          vectors;
    int          miscompares;
    logic [31:0] last_q;

    seq_div32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One division: start sampled at edge 0, cycle k is the cycle after edge k-1.
    task automatic do_div(input string tag, input logic s, input logic [31:0] n,
                          input logic [31:0] d, input logic [31:0] eq, input logic [31:0] er,
                          input logic ediv0, input int elat, input int repulse,
                          input logic poke_done);
        int lat;
        int busy_cnt;
        sgn      = s;
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == 2) chk({tag, "_held_q"}, quotient, last_q);
            if (lat == repulse) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                start    = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(elat - 1));
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_div0"}, {31'd0, div0}, {31'd0, ediv0});
        last_q = eq;
        if (poke_done) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd3;
        end
        tick();
        start = 1'b0;
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_seen;
        vectors     = 0;
        miscompares = 0;
        last_q      = 32'd0;
        rst         = 1'b1;
        start       = 1'b0;
        sgn         = 1'b0;
        dividend    = 32'd0;
        divisor     = 32'd0;
        repeat (2) tick();

        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_div0", {31'd0, div0}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        rst = 1'b0;
        tick();

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0, 1'b0);
        do_div("uffff_8000", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 33, 0, 1'b0);
        do_div("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0, 1'b0);
        // start held during the done cycle must be ignored
        do_div("u1234_0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0, 1'b1);
        // 9/3 re-pulsed in cycle 5 of CALC must not disturb 100/7
        do_div("u100_7_repulse", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 5, 1'b0);
        do_div("u7_2_back2back", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, 0, 1'b0);

        // Reset in cycle 10 of CALC aborts without a done pulse.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (9) tick();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_div0", {31'd0, div0}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        last_q = 32'd0;
        do_div("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 0, 1'b0);

`ifdef SEQDIV_SIGNED_EN
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0, 1'b0);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 0, 1'b0);
        do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 0, 1'b0);
        do_div("s_div0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
